// File: rtl/btn_conditioner.sv
// Push-button conditioner: two-flop synchroniser, stability-count debouncer and
// registered press / release / long-press single-cycle ticks.
module btn_conditioner #(
    parameter int unsigned STABLE_CYCLES = 500000,
    parameter int unsigned LONG_CYCLES   = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db_level,
    output logic press_tick,
    output logic release_tick,
    output logic long_tick
);

    localparam int unsigned CntW  = $clog2(STABLE_CYCLES);
    localparam int unsigned LcntW = $clog2(LONG_CYCLES + 1);
    localparam logic [CntW-1:0]  CntLast = CntW'(STABLE_CYCLES - 1);
    localparam logic [LcntW-1:0] LcntMax = LcntW'(LONG_CYCLES);
    localparam logic [LcntW-1:0] LcntPen = LcntW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {StZero, StWait1, StOne, StWait0} state_e;

    logic             sync1_q, sync2_q;
    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [LcntW-1:0] lcnt_q, lcnt_d;
    logic             db_level_q, db_level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StZero: begin
                if (sync2_q) begin
                    state_d = StWait1;
                    cnt_d   = '0;
                end
            end
            StWait1: begin
                if (!sync2_q) begin
                    state_d = StZero;
                end else if (cnt_q == CntLast) begin
                    state_d = StOne;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StOne: begin
                if (!sync2_q) begin
                    state_d = StWait0;
                    cnt_d   = '0;
                end
            end
            StWait0: begin
                if (sync2_q) begin
                    state_d = StOne;
                end else if (cnt_q == CntLast) begin
                    state_d = StZero;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StZero;
        endcase

        db_level_d = (state_d == StOne) || (state_d == StWait0);
        press_d    = (state_q == StWait1) && (state_d == StOne);
        release_d  = (state_q == StWait0) && (state_d == StZero);

        // Clearing on the next-state level lets a coincident release beat the long tick.
        if (!db_level_d) begin
            lcnt_d = '0;
        end else if (db_level_q && (lcnt_q != LcntMax)) begin
            lcnt_d = lcnt_q + 1'b1;
        end else begin
            lcnt_d = lcnt_q;
        end
        long_d = db_level_d && db_level_q && (lcnt_q == LcntPen);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            state_q    <= StZero;
            cnt_q      <= '0;
            lcnt_q     <= '0;
            db_level_q <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            sync1_q    <= sw;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lcnt_q     <= lcnt_d;
            db_level_q <= db_level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
        end
    end

    assign db_level     = db_level_q;
    assign press_tick   = press_q;
    assign release_tick = release_q;
    assign long_tick    = long_q;

endmodule
